// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and defaults for the multiply/divide unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational mult/multu/div/divu datapath producing {hi,lo}
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic               s_ovf;
    logic        [31:0] s_divisor;
    logic        [31:0] u_divisor;
    logic signed [31:0] s_quo;
    logic signed [31:0] s_rem;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;

    assign div_zero = (B == 32'd0);

    assign s_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign u_prod = {32'd0, A} * {32'd0, B};

    // Most-negative / -1 overflows a 32-bit signed divide. Dividing by 1
    // instead yields exactly the required answer (quotient 0x80000000,
    // remainder 0). A zero divisor is also steered to 1 so the datapath never
    // produces X; the FSM discards that result anyway.
    assign s_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign s_divisor = (div_zero || s_ovf) ? 32'd1 : B;
    assign u_divisor = div_zero ? 32'd1 : B;

    assign s_quo = $signed(A) / $signed(s_divisor);
    assign s_rem = $signed(A) % $signed(s_divisor);
    assign u_quo = A / u_divisor;
    assign u_rem = A % u_divisor;

    // Select the {hi,lo} pair for the requested operation
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = s_prod;
            MD_MULTU: result = u_prod;
            MD_DIV:   result = {s_rem, s_quo};
            MD_DIVU:  result = {u_rem, u_quo};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding HI/LO
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        md_en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_dz;
    logic               is_arith;
    logic               is_div;
    logic [63:0]        calc_result;
    logic               calc_dz;

    assign is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign is_arith = (md_op == MD_MULT) || (md_op == MD_MULTU) || is_div;
    assign start    = md_en && is_arith && !busy;

    md_calc u_calc (
        .op       (md_op),
        .A        (A),
        .B        (B),
        .result   (calc_result),
        .div_zero (calc_dz)
    );

    // Control FSM: latch the result on start, count down, commit on the last busy cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= calc_result[63:32];
                        pend_lo <= calc_result[31:0];
                        pend_dz <= calc_dz && is_div;
                        counter <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (md_en && (md_op == MD_MTHI)) begin
                        hi <= A;
                    end else if (md_en && (md_op == MD_MTLO)) begin
                        lo <= A;
                    end
                end
                RUN: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        if (!pend_dz) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized bench for md_unit against a transaction-level model
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic        md_en;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md_op (md_op),
        .md_en (md_en),
        .A     (A),
        .B     (B),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          chk_on = 1'b0;
    // Model: edges seen, edge at which the in-flight op completes, architectural HI/LO
    longint      cyc = 0;
    longint      done_edge = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_commit = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] rh, output logic [31:0] rl, output bit commit);
        int              ia, ib;
        longint          sa, sb, mag_a, mag_b, q, r, sp;
        longint unsigned ua, ub, up;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        rh = 32'd0; rl = 32'd0; commit = 1'b1;
        case (op)
            3'd1: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            3'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            3'd3: begin
                if (b == 32'd0) commit = 1'b0;
                else begin
                    mag_a = (sa < 0) ? -sa : sa;
                    mag_b = (sb < 0) ? -sb : sb;
                    q = mag_a / mag_b;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r = sa - q * sb;
                    rl = q[31:0]; rh = r[31:0];
                end
            end
            3'd4: begin
                if (b == 32'd0) commit = 1'b0;
                else begin up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0]; end
            end
            default: commit = 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit was_busy;
        was_busy = (cyc < done_edge);
        cyc++;
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; done_edge = cyc; p_commit = 1'b0;
        end else if (was_busy) begin
            if (cyc == done_edge && p_commit) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (md_en) begin
            if (md_op >= 3'd1 && md_op <= 3'd4) begin
                ref_result(md_op, A, B, p_hi, p_lo, p_commit);
                done_edge = cyc + ((md_op <= 3'd2) ? MC : DC);
            end else if (md_op == 3'd5) m_hi = A;
            else if (md_op == 3'd6) m_lo = A;
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic en, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        reset = rst; md_op = op; md_en = en; A = a; B = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string name);
        int n;
        n = 0;
        drive(op, 1'b1, a, b, 1'b0);
        for (int i = 0; i < 20 && busy; i++) begin
            n++;
            drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Every cycle: outputs must equal the model, start must follow its defining rule
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, 64'(cyc < done_edge));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("start", start, 64'(md_en && md_op >= 3'd1 && md_op <= 3'd4 && !(cyc < done_edge)));
        end
    end

    initial begin
        reset = 1'b1; md_op = 3'd0; md_en = 1'b0; A = 32'd0; B = 32'd0;
        drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk_on = 1'b1;
        check("reset_hi", hi, 64'd0);
        check("reset_lo", lo, 64'd0);
        check("reset_busy", busy, 64'd0);

        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000, "div_ovf");

        drive(MD_MTHI, 1'b1, 32'h11, 32'd0, 1'b0);
        drive(MD_MTLO, 1'b1, 32'h22, 32'd0, 1'b0);
        run_op(MD_DIVU, 32'd5, 32'd0, DC, 32'h11, 32'h22, "divu_zero");

        drive(MD_MTHI, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mthi_hi", hi, 64'hDEAD_BEEF);
        check("mthi_busy", busy, 64'd0);
        drive(MD_MTLO, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        check("mtlo_disabled_lo", lo, 64'h22);

        drive(MD_MULT, 1'b1, 32'd7, 32'd9, 1'b0);
        drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("abort_busy", busy, 64'd0);
        check("abort_hi", hi, 64'd0);
        check("abort_lo", lo, 64'd0);
        repeat (8) drive(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("abort_no_commit_lo", lo, 64'd0);

        drive(MD_MULT, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (MC) drive(MD_MULT, 1'b1, 32'd3, 32'd4, 1'b0);
        check("held_busy", busy, 64'd0);
        check("held_hi", hi, 64'd1);
        check("held_lo", lo, 64'd0);
        check("b2b_start", start, 64'd1);
        run_op(MD_MULT, 32'd3, 32'd4, MC, 32'd0, 32'd12, "b2b");

        repeat (600) begin
            logic [2:0]  op;
            logic        en, rst;
            logic [31:0] a, b;
            op  = 3'($urandom_range(0, 7));
            en  = ($urandom_range(0, 3) != 0);
            a   = pick();
            b   = pick();
            rst = ($urandom_range(0, 99) == 0);
            drive(op, en, a, b, rst);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
